// File: rtl/game_sequencer_if.sv
// Game controller bus: debounced player/counter events in, timing strobes and game status out.
interface game_sequencer_if #(
    parameter int SCORE_W = 8
);
    logic               start;
    logic               pause;
    logic               lose;
    logic               hit;
    logic               time_zero;
    logic               tick;
    logic               timer_rst;
    logic [SCORE_W-1:0] score;
    logic [1:0]         state;
    logic               game_over;

    modport master (
        output start, pause, lose, hit, time_zero,
        input  tick, timer_rst, score, state, game_over
    );

    modport slave (
        input  start, pause, lose, hit, time_zero,
        output tick, timer_rst, score, state, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// Game controller: sequences the countdown counter (tick / restart pulses) and tracks the score.
// Define GAME_PAUSE_EN to enable the pause input and the PAUSE state.
module game_sequencer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCORE_W  = 8
) (
    input logic              clk,
    input logic              rst,
    game_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam int                 DIV_W      = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               tick_q, tick_d;
    logic               trst_q, trst_d;
    logic               over_q, over_d;
    logic               pause_ev;

`ifdef GAME_PAUSE_EN
    assign pause_ev = bus.pause;
`else
    logic unused_pause;
    assign unused_pause = bus.pause;
    assign pause_ev     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            score_q <= '0;
            tick_q  <= 1'b0;
            trst_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            score_q <= score_d;
            tick_q  <= tick_d;
            trst_q  <= trst_d;
            over_q  <= over_d;
        end
    end

    // The divider still advances on the edge that leaves PLAY, but the tick
    // is only issued when the next cycle stays in PLAY, so a pending tick is dropped.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        score_d = score_q;
        tick_d  = 1'b0;
        trst_d  = 1'b0;
        case (state_q)
            IDLE, PAUSE, OVER: begin
                if (bus.start) begin
                    state_d = PLAY;
                    trst_d  = 1'b1;
                    score_d = '0;
                    div_d   = '0;
                end else if (state_q == PAUSE && pause_ev) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                // A time_zero seen alongside the restart pulse is the old run's flag.
                if (bus.lose || (bus.time_zero && !trst_q)) begin
                    state_d = OVER;
                end else if (pause_ev) begin
                    state_d = PAUSE;
                end else begin
                    tick_d = (div_q == DIV_LAST);
                    if (bus.hit && score_q != SCORE_MAX)
                        score_d = score_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        over_d = (state_d == OVER);
    end

    assign bus.tick      = tick_q;
    assign bus.timer_rst = trst_q;
    assign bus.score     = score_q;
    assign bus.state     = state_q;
    assign bus.game_over = over_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer with TICK_DIV=4; a second SCORE_W=2 instance covers saturation.
module tb_game_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   passes;

    game_sequencer_if #(.SCORE_W(8)) bus8 ();
    game_sequencer_if #(.SCORE_W(2)) bus2 ();

    game_sequencer #(.TICK_DIV(4), .SCORE_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    game_sequencer #(.TICK_DIV(4), .SCORE_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are checked and inputs changed at the falling edge, half a cycle from the sampling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus8.state !== 2'b00) $display("[TB] FAIL reset_state: got %0d expected 0", bus8.state); else passes++;
        checks++; if (bus8.tick !== 1'b0) $display("[TB] FAIL reset_tick: got %0b expected 0", bus8.tick); else passes++;
        checks++; if (bus8.timer_rst !== 1'b0) $display("[TB] FAIL reset_timer_rst: got %0b expected 0", bus8.timer_rst); else passes++;
        checks++; if (bus8.score !== 8'd0) $display("[TB] FAIL reset_score: got %0d expected 0", bus8.score); else passes++;
        checks++; if (bus8.game_over !== 1'b0) $display("[TB] FAIL reset_game_over: got %0b expected 0", bus8.game_over); else passes++;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        checks++; if (bus8.state !== 2'b00) $display("[TB] FAIL reset_hold_start: got %0d expected 0", bus8.state); else passes++;
        rst = 1'b0;
        step();
        checks++; if (bus8.state !== 2'b00) $display("[TB] FAIL idle_after_release: got %0d expected 0", bus8.state); else passes++;
    endtask

    task automatic test_start_tick();
        logic exp_tick;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        checks++; if (bus8.state !== 2'b01) $display("[TB] FAIL start_state: got %0d expected 1", bus8.state); else passes++;
        checks++; if (bus8.timer_rst !== 1'b1) $display("[TB] FAIL start_timer_rst: got %0b expected 1", bus8.timer_rst); else passes++;
        checks++; if (bus8.tick !== 1'b0) $display("[TB] FAIL start_tick0: got %0b expected 0", bus8.tick); else passes++;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp_tick = (k % 4 == 0);
            checks++; if (bus8.tick !== exp_tick) $display("[TB] FAIL tick_cadence_c%0d: got %0b expected %0b", k, bus8.tick, exp_tick); else passes++;
            if (k == 1) begin
                checks++; if (bus8.timer_rst !== 1'b0) $display("[TB] FAIL timer_rst_width: got %0b expected 0", bus8.timer_rst); else passes++;
            end
        end
    endtask

    task automatic test_hits_lose();
        for (int i = 0; i < 3; i++) begin
            bus8.hit = 1'b1;
            step();
            bus8.hit = 1'b0;
            step();
        end
        checks++; if (bus8.score !== 8'd3) $display("[TB] FAIL three_hits: got %0d expected 3", bus8.score); else passes++;
        // The divider is at its last count here, so this lose also drops a pending tick.
        bus8.lose = 1'b1;
        step();
        bus8.lose = 1'b0;
        checks++; if (bus8.state !== 2'b11) $display("[TB] FAIL lose_state: got %0d expected 3", bus8.state); else passes++;
        checks++; if (bus8.game_over !== 1'b1) $display("[TB] FAIL lose_game_over: got %0b expected 1", bus8.game_over); else passes++;
        checks++; if (bus8.score !== 8'd3) $display("[TB] FAIL lose_score: got %0d expected 3", bus8.score); else passes++;
        checks++; if (bus8.tick !== 1'b0) $display("[TB] FAIL tick_dropped: got %0b expected 0", bus8.tick); else passes++;
        for (int i = 0; i < 6; i++) begin
            bus8.hit   = 1'b1;
            bus8.pause = (i == 2);
            step();
            checks++; if (bus8.score !== 8'd3) $display("[TB] FAIL over_score_c%0d: got %0d expected 3", i, bus8.score); else passes++;
            checks++; if (bus8.state !== 2'b11 || bus8.tick !== 1'b0) $display("[TB] FAIL over_hold_c%0d: got state %0d tick %0b expected state 3 tick 0", i, bus8.state, bus8.tick); else passes++;
        end
        bus8.hit   = 1'b0;
        bus8.pause = 1'b0;
    endtask

    task automatic test_time_zero();
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        checks++; if (bus8.score !== 8'd0) $display("[TB] FAIL restart_score: got %0d expected 0", bus8.score); else passes++;
        checks++; if (bus8.timer_rst !== 1'b1) $display("[TB] FAIL restart_timer_rst: got %0b expected 1", bus8.timer_rst); else passes++;
        bus8.time_zero = 1'b1;
        bus8.hit       = 1'b1;
        step();
        bus8.time_zero = 1'b0;
        checks++; if (bus8.state !== 2'b01) $display("[TB] FAIL stale_time_zero: got %0d expected 1", bus8.state); else passes++;
        checks++; if (bus8.score !== 8'd1) $display("[TB] FAIL masked_cycle_hit: got %0d expected 1", bus8.score); else passes++;
        repeat (4) step();
        checks++; if (bus8.score !== 8'd5) $display("[TB] FAIL five_hits: got %0d expected 5", bus8.score); else passes++;
        bus8.time_zero = 1'b1;
        step();
        bus8.time_zero = 1'b0;
        bus8.hit       = 1'b0;
        checks++; if (bus8.state !== 2'b11) $display("[TB] FAIL time_zero_state: got %0d expected 3", bus8.state); else passes++;
        checks++; if (bus8.score !== 8'd5) $display("[TB] FAIL time_zero_hit_ignored: got %0d expected 5", bus8.score); else passes++;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        checks++; if (bus8.state !== 2'b01) $display("[TB] FAIL over_restart_state: got %0d expected 1", bus8.state); else passes++;
        checks++; if (bus8.score !== 8'd0) $display("[TB] FAIL over_restart_score: got %0d expected 0", bus8.score); else passes++;
        checks++; if (bus8.timer_rst !== 1'b1) $display("[TB] FAIL over_restart_timer_rst: got %0b expected 1", bus8.timer_rst); else passes++;
    endtask

    task automatic test_pause();
        logic exp_tick;
        step();
        checks++; if (bus8.timer_rst !== 1'b0) $display("[TB] FAIL pause_pre_timer_rst: got %0b expected 0", bus8.timer_rst); else passes++;
        bus8.pause = 1'b1;
        bus8.hit   = 1'b1;
        step();
        bus8.pause = 1'b0;
        bus8.hit   = 1'b0;
`ifdef GAME_PAUSE_EN
        checks++; if (bus8.state !== 2'b10) $display("[TB] FAIL pause_state: got %0d expected 2", bus8.state); else passes++;
        checks++; if (bus8.score !== 8'd0) $display("[TB] FAIL pause_hit_ignored: got %0d expected 0", bus8.score); else passes++;
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus8.state !== 2'b10 || bus8.tick !== 1'b0) $display("[TB] FAIL pause_hold_c%0d: got state %0d tick %0b expected state 2 tick 0", i, bus8.state, bus8.tick); else passes++;
            bus8.hit   = 1'b1;
            bus8.lose  = (i == 4);
            bus8.pause = (i == 9);
            step();
        end
        bus8.hit   = 1'b0;
        bus8.lose  = 1'b0;
        bus8.pause = 1'b0;
        checks++; if (bus8.state !== 2'b01) $display("[TB] FAIL resume_state: got %0d expected 1", bus8.state); else passes++;
        checks++; if (bus8.score !== 8'd0) $display("[TB] FAIL paused_score: got %0d expected 0", bus8.score); else passes++;
        for (int k = 0; k < 4; k++) begin
            exp_tick = (k == 2);
            checks++; if (bus8.tick !== exp_tick) $display("[TB] FAIL resume_tick_c%0d: got %0b expected %0b", k, bus8.tick, exp_tick); else passes++;
            step();
        end
`else
        checks++; if (bus8.state !== 2'b01) $display("[TB] FAIL pause_ignored_state: got %0d expected 1", bus8.state); else passes++;
        checks++; if (bus8.score !== 8'd1) $display("[TB] FAIL pause_hit_counted: got %0d expected 1", bus8.score); else passes++;
        for (int i = 0; i < 10; i++) begin
            exp_tick = ((i + 2) % 4 == 0);
            checks++; if (bus8.state !== 2'b01 || bus8.tick !== exp_tick) $display("[TB] FAIL nopause_c%0d: got state %0d tick %0b expected state 1 tick %0b", i + 2, bus8.state, bus8.tick, exp_tick); else passes++;
            bus8.pause = (i == 5);
            step();
        end
        bus8.pause = 1'b0;
        checks++; if (bus8.tick !== 1'b1) $display("[TB] FAIL nopause_tick_c12: got %0b expected 1", bus8.tick); else passes++;
`endif
    endtask

    task automatic test_saturation();
        logic [1:0] exp_score;
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        checks++; if (bus2.state !== 2'b01) $display("[TB] FAIL sat_start_state: got %0d expected 1", bus2.state); else passes++;
        for (int i = 0; i < 5; i++) begin
            bus2.hit = 1'b1;
            step();
            exp_score = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++; if (bus2.score !== exp_score) $display("[TB] FAIL sat_score_h%0d: got %0d expected %0d", i + 1, bus2.score, exp_score); else passes++;
        end
        bus2.hit = 1'b0;
        checks++; if (bus2.state !== 2'b01) $display("[TB] FAIL sat_state: got %0d expected 1", bus2.state); else passes++;
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_pre;
`ifdef GAME_PAUSE_EN
        exp_pre = 8'd1;
`else
        exp_pre = 8'd2;
`endif
        bus8.hit = 1'b1;
        step();
        bus8.hit = 1'b0;
        checks++; if (bus8.score !== exp_pre) $display("[TB] FAIL pre_reset_score: got %0d expected %0d", bus8.score, exp_pre); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus8.state !== 2'b00) $display("[TB] FAIL async_state: got %0d expected 0", bus8.state); else passes++;
        checks++; if (bus8.score !== 8'd0) $display("[TB] FAIL async_score: got %0d expected 0", bus8.score); else passes++;
        checks++; if (bus8.tick !== 1'b0 || bus8.timer_rst !== 1'b0) $display("[TB] FAIL async_strobes: got tick %0b timer_rst %0b expected 0 0", bus8.tick, bus8.timer_rst); else passes++;
        checks++; if (bus2.score !== 2'd0 || bus2.state !== 2'b00) $display("[TB] FAIL async_dut2: got score %0d state %0d expected 0 0", bus2.score, bus2.state); else passes++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus8.state !== 2'b00 || bus8.tick !== 1'b0) $display("[TB] FAIL post_reset_idle_c%0d: got state %0d tick %0b expected 0 0", i, bus8.state, bus8.tick); else passes++;
        end
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        checks++; if (bus8.state !== 2'b01 || bus8.timer_rst !== 1'b1) $display("[TB] FAIL reenter_play: got state %0d timer_rst %0b expected 1 1", bus8.state, bus8.timer_rst); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        bus8.start = 1'b0; bus8.pause = 1'b0; bus8.lose = 1'b0; bus8.hit = 1'b0; bus8.time_zero = 1'b0;
        bus2.start = 1'b0; bus2.pause = 1'b0; bus2.lose = 1'b0; bus2.hit = 1'b0; bus2.time_zero = 1'b0;
        test_reset();
        test_start_tick();
        test_hits_lose();
        test_time_zero();
        test_pause();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
